// File: rtl/rtc_int_ctrl.sv
// RTC interrupt controller: synchronises raw RTC-domain interrupts into PCLK,
// keeps per-channel level/edge status, clear handshake with timeout, and masking.
module rtc_int_ctrl #(
    parameter int                NUM_CH      = 2,
    parameter int                SYNC_STAGES = 2,
    parameter logic [NUM_CH-1:0] EDGE_MODE   = '0,
    parameter int                CLR_TIMEOUT = 255
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic [NUM_CH-1:0] RawIntAsync,
    input  logic [NUM_CH-1:0] IntClr,
    input  logic [NUM_CH-1:0] IntMask,
    input  logic              ErrClr,
    output logic [NUM_CH-1:0] RawIntSync,
    output logic [NUM_CH-1:0] IntClear,
    output logic [NUM_CH-1:0] RIS,
    output logic [NUM_CH-1:0] MIS,
    output logic              IntOut,
    output logic [NUM_CH-1:0] ClrErr
);

    localparam int            CW          = $clog2(CLR_TIMEOUT + 1);
    localparam logic [CW-1:0] TIMEOUT_VAL = CW'(CLR_TIMEOUT);

    logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q;
    logic [NUM_CH-1:0]                  raw_sync;

    logic [NUM_CH-1:0]         clear_q, clear_d;
    logic [NUM_CH-1:0][CW-1:0] cnt_q, cnt_d;
    logic [NUM_CH-1:0]         err_q, err_d;
    logic [NUM_CH-1:0]         stat_q, stat_d;
    logic [NUM_CH-1:0]         prev_q;
    logic [NUM_CH-1:0]         edge_rise;
    logic [NUM_CH-1:0]         timeout;

    assign raw_sync  = sync_q[SYNC_STAGES-1];
    assign edge_rise = raw_sync & ~prev_q;

    always_comb begin
        // NOTE: every next-state signal gets a default before the loop so no path leaves a latch.
        clear_d = '0;
        cnt_d   = '0;
        err_d   = err_q;
        stat_d  = '0;
        timeout = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (EDGE_MODE[ch]) begin
                // A fresh rising edge beats a coincident clear strobe.
                stat_d[ch] = edge_rise[ch] | (stat_q[ch] & ~IntClr[ch]);
            end else begin
                timeout[ch] = raw_sync[ch] & clear_q[ch] & (cnt_q[ch] == TIMEOUT_VAL);
                clear_d[ch] = raw_sync[ch] & ~timeout[ch] & (IntClr[ch] | clear_q[ch]);
                cnt_d[ch]   = clear_d[ch] ? cnt_q[ch] + CW'(1) : '0;
            end
            err_d[ch] = timeout[ch] | (err_q[ch] & ~ErrClr);
        end
    end

    always_ff @(posedge PCLK) begin
        // NOTE: synchronous reset clears the synchroniser chain too; all state uses <=.
        if (!PRESETn) begin
            sync_q  <= '0;
            prev_q  <= '0;
            stat_q  <= '0;
            clear_q <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], RawIntAsync};
            prev_q  <= raw_sync;
            stat_q  <= stat_d;
            clear_q <= clear_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign RawIntSync = raw_sync;
    assign IntClear   = clear_q;
    assign RIS        = (EDGE_MODE & stat_q) | (~EDGE_MODE & raw_sync & ~clear_q);
    assign MIS        = RIS & IntMask;
    assign IntOut     = |MIS;
    assign ClrErr     = err_q;

endmodule
